// File: rtl/mult_accum_ctrl_pkg.sv
// Shared constants and types for the shift-add multiplier slice.
package mult_accum_ctrl_pkg;

    // Existing operand-width constant used by the shift register.
    localparam int NBits = 8;

    // Operand width N; product and accumulator are 2*N bits.
    localparam int NBITS = NBits;

    // Iteration counter must reach NBITS, hence the extra bit.
    localparam int CNT_W = $clog2(NBITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_accum_ctrl.sv
// Control and accumulate stage of the sequential shift-add multiplier.
// Drives the shift register's load/hold, adds the shifted multiplier into
// a 2N-bit accumulator per set multiplicand bit, and hands the product
// out through a valid/ack handshake.
module mult_accum_ctrl
    import mult_accum_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ld,
    output logic                 shift_hold,
    input  logic [2*NBITS-1:0]   mplier_sh,
    input  logic [NBITS-1:0]     mcand_sh,
    output logic                 busy,
    output logic [2*NBITS-1:0]   product,
    output logic                 product_valid,
    input  logic                 product_ack,
    output logic [CNT_W-1:0]     iter_cnt
);

    mult_state_e               r_state;
    mult_state_e               w_next;
    logic [2*NBITS-1:0]        r_acc;
    logic [2*NBITS-1:0]        r_product;
    logic                      r_valid;
    logic [CNT_W-1:0]          r_iter;
    logic [2*NBITS-1:0]        w_sum;
    logic                      w_term;

    // Accumulator plus this iteration's partial product (wraps at 2^(2N)).
    assign w_sum  = r_acc + (mcand_sh[0] ? mplier_sh : '0);

    // Stop early once no multiplicand bits remain above the current one,
    // otherwise after the last bit position.
    assign w_term = (mcand_sh[NBITS-1:1] == '0) ||
                    (r_iter == CNT_W'(NBITS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state and control outputs; ld is combinational so the shifter
    // loads its operands on the same edge the start is accepted.
    always_comb begin
        w_next     = r_state;
        ld         = 1'b0;
        shift_hold = 1'b1;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    ld     = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                shift_hold = 1'b0;
                busy       = 1'b1;
                if (w_term) w_next = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (product_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Accumulator, iteration counter and product/valid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_iter    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_iter <= '0;
                    end
                end
                RUN: begin
                    r_acc  <= w_sum;
                    r_iter <= r_iter + 1'b1;
                    if (w_term) begin
                        r_product <= w_sum;
                        r_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (product_ack) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign product       = r_product;
    assign product_valid = r_valid;
    assign iter_cnt      = r_iter;

endmodule

// File: tb/tb_mult_accum_ctrl.sv
// Bench for mult_accum_ctrl: a behavioural shift register feeds the DUT,
// a cycle-level model predicts every output from the operands alone.
module tb_mult_accum_ctrl;
    import mult_accum_ctrl_pkg::*;

    localparam int W2 = 2 * NBITS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             product_ack = 1'b0;
    logic [NBITS-1:0] op_a = '0;   // multiplier
    logic [NBITS-1:0] op_b = '0;   // multiplicand
    logic             ld, shift_hold, busy, product_valid;
    logic [W2-1:0]    product;
    logic [CNT_W-1:0] iter_cnt;
    logic [W2-1:0]    sh_mplier = '0;
    logic [NBITS-1:0] sh_mcand = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_accum_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ld(ld), .shift_hold(shift_hold),
        .mplier_sh(sh_mplier), .mcand_sh(sh_mcand), .busy(busy),
        .product(product), .product_valid(product_valid),
        .product_ack(product_ack), .iter_cnt(iter_cnt)
    );

    // Stand-in for the existing shift register: load on start, shift when enabled.
    always @(posedge clk) begin
        if (ld) begin
            sh_mplier <= W2'(op_a);
            sh_mcand  <= op_b;
        end else if (!shift_hold) begin
            sh_mplier <= sh_mplier << 1;
            sh_mcand  <= sh_mcand >> 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RUN length: position of the highest set multiplicand bit plus one, at least 1.
    function automatic int run_len(input logic [NBITS-1:0] b);
        int l = 1;
        for (int i = 0; i < NBITS; i++) if (b[i]) l = i + 1;
        return l;
    endfunction

    // Cycle-level model: phase, cycles left, expected product.
    typedef enum int {P_IDLE, P_RUN, P_DONE} phase_e;
    phase_e        m_ph;
    int            m_left;
    int            m_iter;
    logic [W2-1:0] m_exp, m_prod;
    logic          m_valid;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= P_IDLE; m_left <= 0; m_iter <= 0;
            m_exp <= '0; m_prod <= '0; m_valid <= 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin
                    m_ph   <= P_RUN;
                    m_left <= run_len(op_b);
                    m_exp  <= W2'(op_a) * W2'(op_b);
                    m_iter <= 0;
                end
                P_RUN: begin
                    m_iter <= m_iter + 1;
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_ph    <= P_DONE;
                        m_prod  <= m_exp;
                        m_valid <= 1'b1;
                    end
                end
                default: if (product_ack) begin
                    m_ph    <= P_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("ld",            32'(ld),            32'(start && m_ph == P_IDLE));
        chk("shift_hold",    32'(shift_hold),    32'(m_ph != P_RUN));
        chk("busy",          32'(busy),          32'(m_ph != P_IDLE));
        chk("product_valid", 32'(product_valid), 32'(m_valid));
        chk("product",       32'(product),       32'(m_prod));
        chk("iter_cnt",      32'(iter_cnt),      32'(m_iter));
    end

    // Present operands with start for one edge; caller sits just after a posedge.
    task automatic start_op(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after the start edge until product_valid rises (bounded).
    task automatic wait_valid(input string name, input int exp_l);
        int n = 0;
        while (!product_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk(name, 32'(n), 32'(exp_l));
    endtask

    task automatic do_ack();
        product_ack = 1'b1;
        @(posedge clk); #1;
        product_ack = 1'b0;
        chk("ack_to_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(shift_hold), 32'd1);
        chk("rst_prod", 32'(product), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 0x0D x 0x0B: four RUN cycles.
        start_op(8'h0D, 8'h0B);
        wait_valid("lat_0d_0b", 4);
        chk("prod_0d_0b", 32'(product), 32'h008F);
        do_ack();

        // Zero multiplicand: one RUN cycle, zero product.
        start_op(8'hFF, 8'h00);
        wait_valid("lat_ff_00", 1);
        chk("prod_ff_00", 32'(product), 32'h0000);
        do_ack();

        // Full-width operands: eight RUN cycles.
        start_op(8'hFF, 8'hFF);
        wait_valid("lat_ff_ff", 8);
        chk("prod_ff_ff", 32'(product), 32'hFE01);
        chk("iter_ff_ff", 32'(iter_cnt), 32'd8);
        do_ack();

        // Start during RUN is ignored; product holds while ack withheld.
        start_op(8'h0D, 8'h0B);
        @(posedge clk); #1;
        op_a = 8'h01; op_b = 8'h01; start = 1'b1;
        #1 chk("ld_in_run", 32'(ld), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("lat_ign", 2);
        chk("prod_ign", 32'(product), 32'h008F);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(product_valid), 32'd1);
            chk("hold_prod", 32'(product), 32'h008F);
        end
        do_ack();

        // Reset during RUN discards the operation immediately.
        start_op(8'h12, 8'h34);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_hold",  32'(shift_hold), 32'd1);
        chk("mid_rst_valid", 32'(product_valid), 32'd0);
        chk("mid_rst_prod",  32'(product), 32'd0);
        chk("mid_rst_iter",  32'(iter_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_op(8'h03, 8'h05);
        wait_valid("lat_03_05", 3);
        chk("prod_03_05", 32'(product), 32'h000F);

        // Start and ack together in DONE: ack wins, start dropped.
        start = 1'b1; product_ack = 1'b1;
        #1 chk("ld_in_done", 32'(ld), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; product_ack = 1'b0;
        chk("both_busy",  32'(busy), 32'd0);
        chk("both_valid", 32'(product_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_new_op", 32'(busy), 32'd0);
        chk("prod_kept", 32'(product), 32'h000F);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_accum_ctrl.md
Name: mult_accum_ctrl

Overview:
- Control and accumulate stage of the sequential shift-add multiplier. It sits directly downstream of the multiplier shift register.
- It drives the shift register's load and hold controls and consumes its left-shifting 2N-bit multiplier and right-shifting N-bit multiplicand.
- On each iteration it conditionally adds the shifted multiplier into a 2N-bit accumulator. It presents the final product through a valid/ack handshake.

Parameters:
- NBITS, 8, operand width N; product and accumulator are 2*NBITS bits. Value comes from the shared package.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request new multiplication; accepted only in IDLE
- ld  out  1  combinational, = start & (state==IDLE); drives the shifter's start input so operands load on the same edge
- shift_hold  out  1  drives the shifter's enb input; 0 = shift this edge, 1 = hold
- mplier_sh  in  2*NBITS  shifter's left-shifted multiplier value
- mcand_sh  in  NBITS  shifter's right-shifted multiplicand value
- busy  out  1  high in RUN or DONE
- product  out  2*NBITS  result; valid while product_valid=1
- product_valid  out  1  result available
- product_ack  in  1  consumer accepts product
- iter_cnt  out  log2(NBITS)+1  iterations completed in the current operation (debug)

Behaviour:
- Reset (async, rst=0): state=IDLE, acc=0, product=0, product_valid=0, busy=0, shift_hold=1, iter_cnt=0. ld follows its equation (0 while in IDLE with start=0).
- States: IDLE, RUN, DONE.
- IDLE:
  - shift_hold=1.
  - start=1 → ld=1 that cycle; next state RUN; acc←0; iter_cnt←0.
- RUN:
  - shift_hold=0. Each edge: if mcand_sh[0]=1 then acc←acc+mplier_sh (modulo 2^(2N)); iter_cnt←iter_cnt+1.
  - Termination: if mcand_sh[NBITS-1:1]==0 or iter_cnt==NBITS-1, then on that edge: product←acc-plus-term, product_valid←1, next state DONE.
  - The shifter still shifts on the final edge. Its contents are don't-care afterwards.
- RUN length: L = max(1, index of highest set bit of multiplicand + 1).
  - Start accepted at edge 0; RUN occupies cycles 1..L; product_valid rises at edge L.
  - Multiplicand 0 gives L=1 and product 0.
- DONE:
  - shift_hold=1; product and product_valid held stable.
  - product_ack=1 → product_valid←0, next state IDLE. product keeps its last value.
- start while in RUN or DONE: ignored, ld=0, no effect on acc or product.
- start and product_ack high together in DONE: ack is honoured, start is dropped. A new start is accepted only from IDLE, earliest the cycle after ack.
- product_ack in IDLE or RUN: ignored.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. Any partial product is discarded.
- Arithmetic: unsigned only. The 2N-bit sum cannot overflow for N-bit operands.
- Throughput: one result per L+2 cycles minimum (start, L RUN, ack).

Decomposition:
- Shared package (alongside the existing NBits constant):
  - NBITS
  - state enum type mult_state_e {IDLE, RUN, DONE}
  - counter width constant CNT_W = $clog2(NBITS)+1
- Single module; no sub-module needed. The FSM, counter and accumulator are tightly coupled.
- The integration top instantiates this block with the existing shift register. Wiring:
  - ld→start
  - shift_hold→enb
  - out_Multiplier→mplier_sh
  - out_Multiplicand→mcand_sh

Test Plan (NBITS=8, shifter instantiated alongside):
- Multiplier 0x0D, multiplicand 0x0B, start pulse at edge 0 → 4 RUN cycles; product_valid=1 after edge 4; product=0x008F; shift_hold=0 only in cycles 1..4.
- Multiplicand 0x00, multiplier 0xFF → 1 RUN cycle; product=0x0000; product_valid after edge 1.
- 0xFF × 0xFF → 8 RUN cycles; product=0xFE01; iter_cnt=8 at DONE.
- During RUN of 0x0D×0x0B, pulse start with operands 0x01,0x01 → ignored, ld stays 0, product=0x008F. Then hold product_ack=0 for 10 cycles → product_valid and product stable. Ack → IDLE next cycle.
- Start 0x12×0x34, drop rst low at cycle 2 of RUN → all outputs at reset values immediately. Release rst, start 0x03×0x05 → product=0x000F after 3 RUN cycles.
- Start and product_ack asserted in the same cycle while in DONE → return to IDLE, no ld pulse, no new operation.
